dmem_port_ctrl: RTL

- Single-port controller in front of the byte-wide data memory array (one byte per address, little-endian).
- Two requesters share the array: instruction fetch (word reads only) and the load/store path (byte/half/word, signed/unsigned loads).
- Arbitrates round-robin, breaks each access into sequential byte cycles, and assembles or sign-extends load data.
- Flags misaligned or illegal accesses without touching memory.

---
 rtl/dmem_port_ctrl_pkg.sv | 45 ++++
 rtl/dmem_port_ctrl_load_extend.sv | 20 ++
 rtl/dmem_port_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dmem_port_ctrl_pkg.sv
// Shared encodings and access-rule helpers for the data-memory port controller.
package dmem_port_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    CAPT = 2'd2,
    ACK  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_e;

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lsb);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = lsb[0];
      SZ_W:    err = (lsb != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Index of the final byte cycle for a legal size.
  function automatic logic [1:0] size_last_idx(input logic [1:0] size);
    logic [1:0] idx;
    case (size)
      SZ_B:    idx = 2'd0;
      SZ_H:    idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/dmem_port_ctrl_load_extend.sv
// Sign- or zero-extends assembled load data according to access size.
module load_extend
  import dmem_port_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_B:    ext = {{24{raw[7] & ~is_unsigned}}, raw[7:0]};
      SZ_H:    ext = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Round-robin byte-serial port between instruction fetch and load/store onto a byte-wide array.
//   state | meaning
//   IDLE  | sample requests, arbitrate, check alignment
//   XFER  | one array byte per cycle (write, or issue read)
//   CAPT  | capture last read byte, present extended data
//   ACK   | one-cycle ack pulse, update round-robin pointer
module dmem_port_ctrl
  import dmem_port_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ack,
  output logic [31:0]           if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic                  d_unsigned,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_ack,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  state_e                state;
  req_e                  id_q, last_id, g_id;
  logic                  we_q, uns_q;
  logic [1:0]            size_q, idx, nxt_idx, cap_idx;
  logic [31:0]           wdata_q, raw, raw_cap, ext_data;
  logic                  g_we, g_uns, g_err;
  logic [1:0]            g_size;
  logic [DEPTH_LOG2-1:0] g_addr;
  logic [31:0]           g_wdata;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^{if_addr[ADDR_W-1:DEPTH_LOG2], d_addr[ADDR_W-1:DEPTH_LOG2]};
  assign busy = (state != IDLE);

  always_comb begin
    g_id = REQ_IF;
    if (if_req && d_req) g_id = (last_id == REQ_IF) ? REQ_D : REQ_IF;
    else if (d_req)      g_id = REQ_D;

    if (g_id == REQ_D) begin
      g_we    = d_we;
      g_size  = d_size;
      g_uns   = d_unsigned;
      g_addr  = d_addr[DEPTH_LOG2-1:0];
      g_wdata = d_wdata;
    end else begin
      g_we    = 1'b0;
      g_size  = SZ_W;
      g_uns   = 1'b1;
      g_addr  = if_addr[DEPTH_LOG2-1:0];
      g_wdata = 32'd0;
    end
    g_err = access_err(g_size, g_addr[1:0]);

    nxt_idx = idx + 2'd1;
    // Read data lags the issuing byte cycle by one; CAPT holds idx at the last byte.
    cap_idx = (state == CAPT) ? idx : idx - 2'd1;
    raw_cap = raw;
    raw_cap[{cap_idx, 3'b000} +: 8] = mem_rdata;
  end

  load_extend u_load_extend (
    .raw         (raw_cap),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext         (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      id_q      <= REQ_IF;
      last_id   <= REQ_D;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wdata_q   <= 32'd0;
      idx       <= 2'd0;
      raw       <= 32'd0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= 32'd0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= 32'd0;
      d_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            id_q    <= g_id;
            we_q    <= g_we;
            size_q  <= g_size;
            uns_q   <= g_uns;
            wdata_q <= g_wdata;
            idx     <= 2'd0;
            raw     <= 32'd0;
            if (g_err) begin
              state <= ACK;
              if (g_id == REQ_IF) begin
                if_ack   <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= 32'd0;
              end else begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= 32'd0;
              end
            end else begin
              state     <= XFER;
              mem_addr  <= g_addr;
              mem_wdata <= g_wdata[7:0];
              mem_we    <= g_we;
              mem_re    <= ~g_we;
            end
          end
        end
        XFER: begin
          if (idx != 2'd0) raw <= raw_cap;
          if (idx == size_last_idx(size_q)) begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            if (we_q) begin
              state   <= ACK;
              d_ack   <= 1'b1;
              d_err   <= 1'b0;
              d_rdata <= 32'd0;
            end else begin
              state <= CAPT;
            end
          end else begin
            idx       <= nxt_idx;
            mem_addr  <= mem_addr + DEPTH_LOG2'(1);
            mem_wdata <= wdata_q[{nxt_idx, 3'b000} +: 8];
          end
        end
        CAPT: begin
          state <= ACK;
          if (id_q == REQ_IF) begin
            if_ack   <= 1'b1;
            if_err   <= 1'b0;
            if_rdata <= ext_data;
          end else begin
            d_ack   <= 1'b1;
            d_err   <= 1'b0;
            d_rdata <= ext_data;
          end
        end
        ACK: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          last_id <= id_q;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
